// File: rtl/res_station_if.sv
// Bundle between a reservation station and its environment.
// Carries the rename write port, the CDB, the issue handshake and status.
interface res_station_if #(
    parameter int TAG_WIDTH = 3,
    parameter int OP_WIDTH  = 8
);
    logic                 flush;
    logic                 wr_en;
    logic [TAG_WIDTH-1:0] wr_addr;
    logic [OP_WIDTH-1:0]  wr_op;
    logic [31:0]          wr_a;
    logic                 wr_qj_pend;
    logic [TAG_WIDTH-1:0] wr_qj;
    logic [31:0]          wr_vj;
    logic                 wr_qk_pend;
    logic [TAG_WIDTH-1:0] wr_qk;
    logic [31:0]          wr_vk;
    logic                 wr_err;
    logic                 cdb_valid;
    logic [TAG_WIDTH-1:0] cdb_tag;
    logic [31:0]          cdb_data;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [OP_WIDTH-1:0]  issue_op;
    logic [31:0]          issue_vj;
    logic [31:0]          issue_vk;
    logic [31:0]          issue_a;
    logic [TAG_WIDTH-1:0] issue_tag;
    logic                 full;
    logic [TAG_WIDTH:0]   count;

    modport master (
        output flush, wr_en, wr_addr, wr_op, wr_a,
        output wr_qj_pend, wr_qj, wr_vj,
        output wr_qk_pend, wr_qk, wr_vk,
        output cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  wr_err, issue_valid, issue_op,
        input  issue_vj, issue_vk, issue_a, issue_tag,
        input  full, count
    );

    modport slave (
        input  flush, wr_en, wr_addr, wr_op, wr_a,
        input  wr_qj_pend, wr_qj, wr_vj,
        input  wr_qk_pend, wr_qk, wr_vk,
        input  cdb_valid, cdb_tag, cdb_data, issue_ready,
        output wr_err, issue_valid, issue_op,
        output issue_vj, issue_vk, issue_a, issue_tag,
        output full, count
    );
endinterface

// File: rtl/res_station.sv
// Reservation station: holds renamed ops until both operands are captured
// from the CDB, then issues the lowest-index ready entry through a
// registered valid/ready stage.
// Ports: clk, rst (sync, active-high), bus (res_station_if.slave):
//   write port wr_*, error pulse wr_err, CDB cdb_*, issue handshake
//   issue_*, status full/count. Entry index doubles as producer tag.
module res_station #(
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = 3,
    parameter int OP_WIDTH  = 8
) (
    input logic            clk,
    input logic            rst,
    res_station_if.slave   bus
);
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     jp;
    logic [DEPTH-1:0]     kp;
    logic [OP_WIDTH-1:0]  op_q [DEPTH];
    logic [31:0]          a_q  [DEPTH];
    logic [31:0]          vj_q [DEPTH];
    logic [31:0]          vk_q [DEPTH];
    logic [TAG_WIDTH-1:0] qj_q [DEPTH];
    logic [TAG_WIDTH-1:0] qk_q [DEPTH];

    logic                 iv;
    logic [OP_WIDTH-1:0]  iop;
    logic [31:0]          ivj;
    logic [31:0]          ivk;
    logic [31:0]          ia;
    logic [TAG_WIDTH-1:0] itag;
    logic                 err;

    logic [DEPTH-1:0]     ready;
    logic                 sel_hit;
    logic [TAG_WIDTH-1:0] sel;
    logic [TAG_WIDTH:0]   cnt;
    logic                 load;
    logic                 wr_ok;
    logic                 byp_j;
    logic                 byp_k;

    assign ready = busy & ~jp & ~kp;

    // Scan from the top so the lowest ready index wins.
    always_comb begin
        sel_hit = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_hit = 1'b1;
                sel     = TAG_WIDTH'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{TAG_WIDTH{1'b0}}, busy[i]};
        end
    end

    assign load  = sel_hit && (!iv || bus.issue_ready);
    assign wr_ok = bus.wr_en && !busy[bus.wr_addr];
    // A write whose producer broadcasts this very cycle is stored ready.
    assign byp_j = bus.cdb_valid && (bus.cdb_tag == bus.wr_qj);
    assign byp_k = bus.cdb_valid && (bus.cdb_tag == bus.wr_qk);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy <= '0;
            iv   <= 1'b0;
            iop  <= '0;
            ivj  <= '0;
            ivk  <= '0;
            ia   <= '0;
            itag <= '0;
            err  <= 1'b0;
        end else begin
            err <= bus.wr_en && busy[bus.wr_addr];
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && jp[i] && bus.cdb_valid &&
                    qj_q[i] == bus.cdb_tag) begin
                    vj_q[i] <= bus.cdb_data;
                    jp[i]   <= 1'b0;
                end
                if (busy[i] && kp[i] && bus.cdb_valid &&
                    qk_q[i] == bus.cdb_tag) begin
                    vk_q[i] <= bus.cdb_data;
                    kp[i]   <= 1'b0;
                end
            end
            if (load) begin
                iv        <= 1'b1;
                iop       <= op_q[sel];
                ivj       <= vj_q[sel];
                ivk       <= vk_q[sel];
                ia        <= a_q[sel];
                itag      <= sel;
                busy[sel] <= 1'b0;
            end else if (bus.issue_ready) begin
                iv <= 1'b0;
            end
            // wr_ok implies the target was idle, so it never collides
            // with the entry being issued.
            if (wr_ok) begin
                busy[bus.wr_addr] <= 1'b1;
                op_q[bus.wr_addr] <= bus.wr_op;
                a_q[bus.wr_addr]  <= bus.wr_a;
                qj_q[bus.wr_addr] <= bus.wr_qj;
                qk_q[bus.wr_addr] <= bus.wr_qk;
                jp[bus.wr_addr]   <= bus.wr_qj_pend && !byp_j;
                kp[bus.wr_addr]   <= bus.wr_qk_pend && !byp_k;
                vj_q[bus.wr_addr] <= (bus.wr_qj_pend && byp_j) ?
                                     bus.cdb_data : bus.wr_vj;
                vk_q[bus.wr_addr] <= (bus.wr_qk_pend && byp_k) ?
                                     bus.cdb_data : bus.wr_vk;
            end
        end
    end

    assign bus.wr_err      = err;
    assign bus.issue_valid = iv;
    assign bus.issue_op    = iop;
    assign bus.issue_vj    = ivj;
    assign bus.issue_vk    = ivk;
    assign bus.issue_a     = ia;
    assign bus.issue_tag   = itag;
    assign bus.full        = &busy;
    assign bus.count       = cnt;
endmodule
